// File: rtl/mem_pkg.sv
// Shared memory-access definitions: size encodings plus the alignment and
// byte-enable rules, common to the load and store paths.
package mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'b00,
      SZ_HALF  = 2'b01,
      SZ_WORD  = 2'b10,
      SZ_DWORD = 2'b11
   } memSize_e;

   localparam int ADDR_W = 32;

   // Misaligned for its size, or a dword on a bus that cannot carry one.
   function automatic logic addrErr(input logic [1:0] size, input logic [2:0] lowAddr,
                                    input logic dwordOk);
      case (memSize_e'(size))
         SZ_BYTE:  addrErr = 1'b0;
         SZ_HALF:  addrErr = lowAddr[0];
         SZ_WORD:  addrErr = |lowAddr[1:0];
         default:  addrErr = !dwordOk | (|lowAddr);
      endcase
   endfunction

   // Byte mask for an 8-byte bus; narrower buses take the low bits.
   function automatic logic [7:0] byteMask(input logic [1:0] size, input logic [2:0] off);
      logic [7:0] base;
      case (memSize_e'(size))
         SZ_BYTE:  base = 8'h01;
         SZ_HALF:  base = 8'h03;
         SZ_WORD:  base = 8'h0F;
         default:  base = 8'hFF;
      endcase
      byteMask = base << off;
   endfunction

endpackage

// File: rtl/store_align.sv
// Combinational store lane steering: byte enables, lane-positioned data and
// the misalignment flag for one store request.
module store_align
   import mem_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]          size,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] be,
   output logic [DATA_W-1:0]   laneData,
   output logic                misaligned
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);

   logic [OFF_W-1:0] off;
   logic [7:0]       mask8;
   logic [7:0]       sizeMask;
   logic [DATA_W-1:0] keep;

   assign off        = addr[OFF_W-1:0];
   assign mask8      = byteMask(size, 3'(off));
   assign be         = mask8[BYTES-1:0];
   assign misaligned = addrErr(size, addr[2:0], DATA_W == 64);

   // Bits above the access size are cleared before steering so unused lanes stay zero.
   always_comb begin
      keep     = '0;
      sizeMask = byteMask(size, 3'd0);
      for (int b = 0; b < BYTES; b++) keep[8*b +: 8] = {8{sizeMask[b]}};
      laneData = (wdata & keep) << {off, 3'b000};
   end

endmodule

// File: rtl/store_buffer.sv
// M-stage store buffer: FIFO of aligned stores draining to data memory, with
// a load-conflict compare against every buffered entry.
module store_buffer
   import mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                st_valid,
   input  logic [1:0]          st_size,
   input  logic [ADDR_W-1:0]   st_addr,
   input  logic [DATA_W-1:0]   st_wdata,
   input  logic                st_flush,
   output logic                st_ades,
   output logic                st_ready,
   output logic                mem_req,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_ack,
   input  logic [ADDR_W-1:0]   ld_addr,
   output logic                ld_hit,
   output logic                empty
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] addrQ [DEPTH];
   logic [BYTES-1:0]  beQ   [DEPTH];
   logic [DATA_W-1:0] dataQ [DEPTH];

   logic [PTR_W-1:0] wrPtr, rdPtr;
   logic [PTR_W:0]   count;
   logic             full, push, pop, misaligned;
   logic [BYTES-1:0]  alignBe;
   logic [DATA_W-1:0] alignData;
   logic [ADDR_W-1:0] alignAddr, ldAligned;

   store_align #(.DATA_W(DATA_W)) uAlign (
      .size       (st_size),
      .addr       (st_addr),
      .wdata      (st_wdata),
      .be         (alignBe),
      .laneData   (alignData),
      .misaligned (misaligned)
   );

   assign alignAddr = {st_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign ldAligned = {ld_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

   assign st_ades  = st_valid & misaligned;
   assign full     = count == (PTR_W+1)'(DEPTH);
   assign empty    = count == '0;
   assign st_ready = !full;
   assign push     = st_valid & st_ready & !st_ades & !st_flush;
   assign pop      = !empty & mem_ack;

   assign mem_req   = !empty;
   assign mem_addr  = addrQ[rdPtr];
   assign mem_be    = beQ[rdPtr];
   assign mem_wdata = dataQ[rdPtr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage needs no reset; validity comes from the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         addrQ[wrPtr] <= alignAddr;
         beQ[wrPtr]   <= alignBe;
         dataQ[wrPtr] <= alignData;
      end
   end

   // An entry is live when its distance from the read pointer is below count.
   always_comb begin
      logic [PTR_W-1:0] rel;
      ld_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         rel = PTR_W'(i) - rdPtr;
         if (({1'b0, rel} < count) && (addrQ[i] == ldAligned)) ld_hit = 1'b1;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Store buffer bench: directed stores with hand-computed expectations; a
// negedge monitor checks each accepted memory write against a scoreboard.
module tb_store_buffer;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;

   logic        clk = 1'b0;
   logic        rst, st_valid, st_flush, mem_ack;
   logic [1:0]  st_size;
   logic [31:0] st_addr, st_wdata, ld_addr;
   logic        st_ades, st_ready, mem_req, ld_hit, empty;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } wr_t;

   wr_t sb[$];
   int  tests = 0;
   int  errors = 0;

   store_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .st_valid(st_valid), .st_size(st_size), .st_addr(st_addr),
      .st_wdata(st_wdata), .st_flush(st_flush), .st_ades(st_ades), .st_ready(st_ready),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .ld_addr(ld_addr), .ld_hit(ld_hit), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && mem_req && mem_ack) begin
         if (sb.size() == 0) begin
            tests++;
            errors++;
            $display("FAIL unexpected_write: addr 0x%0h with empty scoreboard", mem_addr);
         end else begin
            wr_t e;
            e = sb.pop_front();
            check("wr_addr", {32'h0, mem_addr}, {32'h0, e.addr});
            check("wr_be", {60'h0, mem_be}, {60'h0, e.be});
            check("wr_data", {32'h0, mem_wdata}, {32'h0, e.data});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doStore(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                          input logic fl, input logic expAdes, input logic expPush,
                          input logic [31:0] eA, input logic [3:0] eBe, input logic [31:0] eD);
      st_valid = 1'b1; st_size = sz; st_addr = a; st_wdata = d; st_flush = fl;
      @(negedge clk);
      check("st_ades", {63'h0, st_ades}, {63'h0, expAdes});
      if (expPush) sb.push_back('{addr: eA, be: eBe, data: eD});
      tick();
      st_valid = 1'b0; st_flush = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      mem_ack = 1'b1;
      while (sb.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'h0);
   endtask

   initial begin
      rst = 1'b1; st_valid = 1'b0; st_flush = 1'b0; mem_ack = 1'b0;
      st_size = 2'b00; st_addr = '0; st_wdata = '0; ld_addr = 32'hFFFF_FFF0;
      tick(); tick();
      rst = 1'b0;
      check("rst_mem_req", {63'h0, mem_req}, 64'h0);
      check("rst_empty", {63'h0, empty}, 64'h1);
      check("rst_st_ready", {63'h0, st_ready}, 64'h1);
      check("rst_ld_hit", {63'h0, ld_hit}, 64'h0);

      // Byte store; no bypass, so mem_req is still low in the push cycle.
      mem_ack = 1'b1;
      st_valid = 1'b1; st_size = 2'b00; st_addr = 32'h1003; st_wdata = 32'hAB;
      @(negedge clk);
      check("sb_no_bypass", {63'h0, mem_req}, 64'h0);
      sb.push_back('{addr: 32'h1000, be: 4'b1000, data: 32'hAB00_0000});
      tick();
      st_valid = 1'b0;
      tick();
      doStore(2'b00, 32'h1001, 32'h1234_56CD, 0, 0, 1, 32'h1000, 4'b0010, 32'h0000_CD00);
      tick();

      // Misaligned half is refused; flushed word is refused.
      doStore(2'b01, 32'h2001, 32'h1234, 0, 1, 0, 0, 0, 0);
      check("ades_no_req", {63'h0, mem_req}, 64'h0);
      doStore(2'b01, 32'h2002, 32'h1234, 0, 0, 1, 32'h2000, 4'b1100, 32'h1234_0000);
      tick();
      doStore(2'b10, 32'h3000, 32'h5555_5555, 1, 0, 0, 0, 0, 0);
      check("flush_no_req", {63'h0, mem_req}, 64'h0);
      doStore(2'b11, 32'h3008, 32'h1, 0, 1, 0, 0, 0, 0);
      doStore(2'b10, 32'h3006, 32'h1, 0, 1, 0, 0, 0, 0);

      // Fill, refuse a 5th, then drain in order.
      mem_ack = 1'b0;
      for (int i = 0; i < 4; i++)
         doStore(2'b10, 32'h10 + 32'(4*i), 32'h1111_1111 * 32'(i+1), 0, 0, 1,
                 32'h10 + 32'(4*i), 4'b1111, 32'h1111_1111 * 32'(i+1));
      check("full_st_ready", {63'h0, st_ready}, 64'h0);
      doStore(2'b10, 32'h20, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
      ld_addr = 32'h12;
      #1 check("full_ld_hit", {63'h0, ld_hit}, 64'h1);
      ld_addr = 32'h30;
      #1 check("full_ld_miss", {63'h0, ld_hit}, 64'h0);
      check("stall_head", {32'h0, mem_addr}, 64'h10);
      mem_ack = 1'b1;
      tick();
      check("ready_after_pop", {63'h0, st_ready}, 64'h1);
      drain(10);
      tick();

      // Count=2, simultaneous push and pop keeps order.
      mem_ack = 1'b0;
      doStore(2'b10, 32'h50, 32'hA, 0, 0, 1, 32'h50, 4'b1111, 32'hA);
      doStore(2'b10, 32'h54, 32'hB, 0, 0, 1, 32'h54, 4'b1111, 32'hB);
      mem_ack = 1'b1;
      doStore(2'b10, 32'h58, 32'hC, 0, 0, 1, 32'h58, 4'b1111, 32'hC);
      mem_ack = 1'b0;
      check("pp_head", {32'h0, mem_addr}, 64'h54);
      check("pp_ready", {63'h0, st_ready}, 64'h1);
      doStore(2'b10, 32'h5C, 32'hD, 0, 0, 1, 32'h5C, 4'b1111, 32'hD);
      doStore(2'b10, 32'h60, 32'hE, 0, 0, 1, 32'h60, 4'b1111, 32'hE);
      check("pp_full", {63'h0, st_ready}, 64'h0);
      drain(10);
      tick();

      // Load conflict: same-cycle push is not visible; buffered entry is.
      mem_ack = 1'b0;
      ld_addr = 32'h42;
      st_valid = 1'b1; st_size = 2'b10; st_addr = 32'h40; st_wdata = 32'h4040_4040;
      @(negedge clk);
      check("hit_not_same_cycle", {63'h0, ld_hit}, 64'h0);
      sb.push_back('{addr: 32'h40, be: 4'b1111, data: 32'h4040_4040});
      tick();
      st_valid = 1'b0;
      check("hit_buffered", {63'h0, ld_hit}, 64'h1);
      ld_addr = 32'h44;
      #1 check("hit_next_word", {63'h0, ld_hit}, 64'h0);
      ld_addr = 32'h42;
      drain(5);
      #1 check("hit_after_pop", {63'h0, ld_hit}, 64'h0);

      // Reset with three outstanding entries and mem_ack high.
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++)
         doStore(2'b10, 32'h80 + 32'(4*i), 32'(i), 0, 0, 1, 32'h80 + 32'(4*i), 4'b1111, 32'(i));
      check("pre_rst_req", {63'h0, mem_req}, 64'h1);
      rst = 1'b1; mem_ack = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      check("post_rst_req", {63'h0, mem_req}, 64'h0);
      check("post_rst_empty", {63'h0, empty}, 64'h1);
      check("post_rst_ready", {63'h0, st_ready}, 64'h1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("post_rst_idle", {63'h0, mem_req}, 64'h0);
      end
      check("sb_empty", 64'(sb.size()), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DATA_W, default 32, memory data width in bits; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 4, number of buffered store entries; power of 2, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 st_valid  input  1  M-stage store request.
REQ-006 st_size  input  2  access size: 00 byte, 01 half, 10 word, 11 dword (dword legal only when DATA_W=64).
REQ-007 st_addr  input  32  byte address of the store.
REQ-008 st_wdata  input  DATA_W  store data, right-justified.
REQ-009 st_flush  input  1  exception/flush for the current M-stage store.
REQ-010 st_ades  output  1  address-error-on-store flag (combinational).
REQ-011 st_ready  output  1  buffer can accept a store.
REQ-012 mem_req  output  1  head entry valid toward data memory.
REQ-013 mem_addr  output  32  head address, aligned to DATA_W/8 bytes.
REQ-014 mem_be  output  DATA_W/8  head byte enables.
REQ-015 mem_wdata  output  DATA_W  head data, lane-positioned.
REQ-016 mem_ack  input  1  memory accepted the head entry.
REQ-017 ld_addr  input  32  M-stage load address, used for conflict check.
REQ-018 ld_hit  output  1  a buffered store overlaps the load's aligned word.
REQ-019 empty  output  1  no buffered entries.

Function
REQ-020 st_ades SHALL be 1 when st_valid=1 and st_addr is not a multiple of the access size, or when st_size=11 and DATA_W=32; otherwise 0.
REQ-021 Byte enables: size S at byte offset o = st_addr[log2(DATA_W/8)-1:0] SHALL set bits o through o+S-1, with all other bits 0.
REQ-022 Data SHALL be shifted left by 8*o bits into its lanes; unused lanes SHALL be 0.
REQ-023 A push SHALL occur when st_valid & st_ready & !st_ades & !st_flush; it stores the aligned address, byte enables and data.
REQ-024 st_ready SHALL equal !full; there is no bypass from input to memory.
REQ-025 A pushed entry SHALL appear on mem_req/mem_addr/mem_be/mem_wdata no earlier than the next cycle (1-cycle minimum latency).
REQ-026 mem_req SHALL equal !empty, and the head outputs SHALL hold stable while mem_req=1 and mem_ack=0.
REQ-027 A pop SHALL occur when mem_req & mem_ack; entries drain in strict FIFO order.
REQ-028 Simultaneous push and pop SHALL leave the count unchanged; when full, a push is refused even if a pop occurs in the same cycle.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH; the count width is clog2(DEPTH)+1.
REQ-030 mem_ack while empty SHALL be ignored.
REQ-031 ld_hit SHALL be 1 when any valid entry's aligned address equals ld_addr with its low log2(DATA_W/8) bits cleared; it does not include a same-cycle push.
REQ-032 st_flush SHALL block only the current push and SHALL NOT discard already-buffered entries.

Reset
REQ-033 While rst=1 at a clock edge, count and pointers SHALL be set to 0 and all buffered entries discarded.
REQ-034 After reset: mem_req=0, empty=1, st_ready=1, ld_hit=0; entry storage contents are don't-care.
REQ-035 Reset during an outstanding mem_req SHALL drop mem_req at that edge, regardless of mem_ack.

Structure
REQ-036 The size encodings and the ades/byte-enable rule SHALL live in a shared package mem_pkg, reused by the load path.
REQ-037 The byte-enable and data-lane generator SHALL be a combinational sub-module store_align; the FIFO and the conflict compare SHALL stay in store_buffer.

Verification (DATA_W=32, DEPTH=4)
REQ-038 SB at addr 0x00001003, data 0xAB, mem_ack=1 -> the next cycle shows mem_addr 0x00001000, mem_be 1000, mem_wdata 0xAB000000.
REQ-039 SH at addr 0x00002001 -> st_ades=1, no push, mem_req stays 0; SH at 0x00002002 with data 0x1234 -> mem_be 1100, mem_wdata 0x12340000.
REQ-040 Four SW pushes (addrs 0x10, 0x14, 0x18, 0x1C) with mem_ack=0 -> st_ready=0 after the 4th and a 5th store is refused; then mem_ack=1 -> addresses drain in order 0x10, 0x14, 0x18, 0x1C, and st_ready=1 after the first pop.
REQ-041 With count=2, push and pop in the same cycle -> count stays 2 and the FIFO order is preserved.
REQ-042 Buffered SW to 0x40, ld_addr 0x42 -> ld_hit=1 until the entry is popped; ld_addr 0x44 -> ld_hit=0.
REQ-043 rst asserted with 3 entries and mem_req=1 -> at the next edge mem_req=0, empty=1, st_ready=1, and no further mem_req occurs without a new push.
